// File: rtl/aes_kx_pkg.sv
// Shared definitions for the AES key-expansion datapath: FSM states, GF(2^4)
// and composite-field constants, and the basis-change matrices between the
// AES field GF(2^8)/0x11B and GF((2^4)^2) built on x^4+x+1 and x^2+x+lambda.
package aes_kx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] GF4_POLY   = 5'b10011;  // x^4 + x + 1
  localparam logic [3:0] GF4_LAMBDA = 4'hC;      // x^2 + x + lambda is irreducible over GF(2^4)
  localparam logic [7:0] AFFINE_C   = 8'h63;
  localparam logic [7:0] AES_RED    = 8'h1B;     // low byte of x^8+x^4+x^3+x+1

  function automatic logic [3:0] gf4_mul_f(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? GF4_POLY[3:0] : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul_f(a, a);
  endfunction

  // Inverse table for GF(2^4)/x^4+x+1; 0 maps to 0.
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'h0;  4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;
      4'h4: r = 4'hD;  4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;
      4'h8: r = 4'hF;  4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;
      4'hC: r = 4'hA;  4'hD: r = 4'h4;  4'hE: r = 4'h3;  default: r = 4'h8;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? AES_RED : 8'h00);
    end
    return p;
  endfunction

  // GF(2) matrix-vector product; cols[8j+7:8j] is the image of input bit j.
  function automatic logic [7:0] mat_apply(input logic [63:0] cols, input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < 8; j++)
      if (v[j]) r = r ^ cols[8*j +: 8];
    return r;
  endfunction

  // Composite -> AES basis. Find Y (root of y^4+y+1) and X (root of
  // x^2+x+lambda(Y)) inside the AES field; composite bit i is Y^i, bit 4+i is Y^i*X.
  function automatic logic [63:0] calc_iso_inv();
    logic [7:0]  y, xa, lam, yp, c, c2;
    logic [63:0] cols;
    y    = 8'h00;
    xa   = 8'h00;
    lam  = 8'h00;
    cols = 64'h0;
    for (int k = 2; k < 256; k++) begin
      c  = 8'(k);
      c2 = gf8_mul(c, c);
      if (y == 8'h00 && (gf8_mul(c2, c2) ^ c ^ 8'h01) == 8'h00) y = c;
    end
    yp = 8'h01;
    for (int i = 0; i < 4; i++) begin
      if (GF4_LAMBDA[i]) lam = lam ^ yp;
      yp = gf8_mul(yp, y);
    end
    for (int k = 1; k < 256; k++) begin
      c = 8'(k);
      if (xa == 8'h00 && (gf8_mul(c, c) ^ c ^ lam) == 8'h00) xa = c;
    end
    yp = 8'h01;
    for (int i = 0; i < 4; i++) begin
      cols[8*i +: 8]     = yp;
      cols[8*(i+4) +: 8] = gf8_mul(yp, xa);
      yp = gf8_mul(yp, y);
    end
    return cols;
  endfunction

  // AES -> composite basis: invert the matrix above column by column.
  function automatic logic [63:0] calc_iso(input logic [63:0] inv_cols);
    logic [63:0] cols;
    cols = 64'h0;
    for (int k = 0; k < 8; k++)
      for (int v = 0; v < 256; v++)
        if (mat_apply(inv_cols, 8'(v)) == (8'h01 << k)) cols[8*k +: 8] = 8'(v);
    return cols;
  endfunction

  localparam logic [63:0] ISO_INV = calc_iso_inv();
  localparam logic [63:0] ISO_FWD = calc_iso(ISO_INV);

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[3'(i + 4)] ^ b[3'(i + 5)] ^ b[3'(i + 6)] ^ b[3'(i + 7)] ^ AFFINE_C[i];
    return r;
  endfunction

endpackage

// File: rtl/gf4_mul.sv
// GF(2^4) multiplier over x^4+x+1, purely combinational.
module gf4_mul
  import aes_kx_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);

  logic [3:0] acc;
  logic [3:0] sh;

  // Shift-and-add with reduction on each shift.
  always_comb begin
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? GF4_POLY[3:0] : 4'h0);
    end
  end

  assign p = acc;

endmodule

// File: rtl/sbox_cf.sv
// Composite-field AES S-box. Inversion is done in GF((2^4)^2):
// (h*X + l)^-1 = h*d^-1 * X + (h+l)*d^-1, d = lambda*h^2 + l*(h+l).
// With SBOX_REG=1 the inverted byte is registered ahead of the affine stage.
module sbox_cf
  import aes_kx_pkg::*;
#(
  parameter bit SBOX_REG = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] iso_b;
  logic [3:0] hi, lo, hl_sum;
  logic [3:0] l_hl, d, d_inv;
  logic [3:0] inv_hi, inv_lo;
  logic [7:0] inv_b;
  logic [7:0] aff_in;

  assign iso_b  = mat_apply(ISO_FWD, in_byte);
  assign hi     = iso_b[7:4];
  assign lo     = iso_b[3:0];
  assign hl_sum = hi ^ lo;

  gf4_mul u_mul_d  (.a(lo),     .b(hl_sum), .p(l_hl));

  assign d     = gf4_mul_f(GF4_LAMBDA, gf4_sq(hi)) ^ l_hl;
  assign d_inv = gf4_inv(d);

  gf4_mul u_mul_hi (.a(hi),     .b(d_inv),  .p(inv_hi));
  gf4_mul u_mul_lo (.a(hl_sum), .b(d_inv),  .p(inv_lo));

  assign inv_b = mat_apply(ISO_INV, {inv_hi, inv_lo});

  generate
    if (SBOX_REG) begin : g_reg
      logic [7:0] inv_q;
      // Pipeline register between inversion and affine stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv_q <= 8'h00;
        else        inv_q <= inv_b;
      end
      assign aff_in = inv_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign aff_in = inv_b;
    end
  endgenerate

  assign out_byte = affine(aff_in);

endmodule

// File: rtl/sub_word_seq.sv
// Sequential RotWord/SubWord/Rcon unit: one shared S-box, one byte per slot,
// least-significant byte first, result held until the consumer takes it.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | in_ready=1, waiting for a word
//   ST_RUN  | substituting byte idx; one slot = 1 cycle (2 with SBOX_REG)
//   ST_DONE | out_valid=1, out_word held until out_ready
module sub_word_seq
  import aes_kx_pkg::*;
#(
  parameter bit SBOX_REG = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic        in_rot,
  input  logic [7:0]  in_rcon,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word
);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        phase, phase_nxt;
  logic [31:0] word_q, word_nxt;
  logic [31:0] res_q, res_nxt;
  logic [7:0]  rcon_q, rcon_nxt;
  logic [7:0]  sb_in, sb_out;
  logic        slot_end;

  // Byte select feeding the shared S-box.
  always_comb begin
    sb_in = word_q[7:0];
    case (idx)
      2'd0:    sb_in = word_q[7:0];
      2'd1:    sb_in = word_q[15:8];
      2'd2:    sb_in = word_q[23:16];
      default: sb_in = word_q[31:24];
    endcase
  end

  sbox_cf #(.SBOX_REG(SBOX_REG)) u_sbox (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_byte  (sb_in),
    .out_byte (sb_out)
  );

  // With the registered S-box the result is ready on the second cycle of a slot.
  assign slot_end = SBOX_REG ? phase : 1'b1;

  // Next-state, byte counter and result-register update.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase;
    word_nxt  = word_q;
    rcon_nxt  = rcon_q;
    res_nxt   = res_q;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          word_nxt  = in_rot ? {in_word[23:0], in_word[31:24]} : in_word;
          rcon_nxt  = in_rcon;
          idx_nxt   = 2'd0;
          phase_nxt = 1'b0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        phase_nxt = ~phase;
        if (slot_end) begin
          phase_nxt = 1'b0;
          case (idx)
            2'd0:    res_nxt[7:0]   = sb_out;
            2'd1:    res_nxt[15:8]  = sb_out;
            2'd2:    res_nxt[23:16] = sb_out;
            default: res_nxt[31:24] = sb_out ^ rcon_q;
          endcase
          if (idx == 2'd3) state_nxt = ST_DONE;
          else             idx_nxt   = idx + 2'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= 2'd0;
      phase  <= 1'b0;
      word_q <= 32'h0;
      res_q  <= 32'h0;
      rcon_q <= 8'h00;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      phase  <= phase_nxt;
      word_q <= word_nxt;
      res_q  <= res_nxt;
      rcon_q <= rcon_nxt;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_word  = res_q;

endmodule
